pipeline_hazard_ctrl: RTL and testbench

Pipeline sequencer for the 5-stage MIPS core. It owns the enable and flush strobes of the PC, the IF/ID, ID/EXE and EXE/MEM registers, and a bubble strobe for MEM/WB. It resolves three cases:
- load-use hazards against the ID/EXE register;
- taken branches or jumps resolved in EXE;
- multi-cycle data-memory accesses, with a timeout that halts the core.

It also keeps saturating stall and flush counters for performance debug.

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/sat_counter.sv | 25 ++
 rtl/pipeline_hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencer.
package pipe_ctrl_pkg;

    // Default register-address width of the MIPS core.
    localparam int DEF_ASIZE = 5;

    // Sequencer states: normal issue, waiting on a slow data access, dead.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low reset.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Next value that sticks at all-ones instead of wrapping.
    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Count register; holds once all-ones is reached.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, EXE redirects, slow data-memory
// freezes with timeout, and saturating stall/flush performance counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ASIZE       = DEF_ASIZE,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ASIZE-1:0] id_rs,
    input  logic [ASIZE-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [ASIZE-1:0] ex_waddr,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // wait_cnt only has to reach MEM_TIMEOUT-2: the RUN cycle that launches
    // the access is the first freeze cycle, MEM_WAIT covers the rest.
    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT - 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 2);

    state_t            state, state_nx;
    logic [WAIT_W-1:0] wait_cnt, wait_nx;
    logic              err_nx;
    logic              freeze, lu, stall_inc, flush_inc;

    // Hazard detection from the current state and pipeline fields.
    always_comb begin
        freeze = ((state == RUN) && mem_req && !mem_ack)
               || ((state == MEM_WAIT) && !mem_ack)
               || (state == HALT);
        lu = ex_memread && (ex_waddr != '0)
           && ((ex_waddr == id_rs) || (id_uses_rt && (ex_waddr == id_rt)));
        stall_inc = (freeze && (state != HALT)) || (!freeze && !ex_redirect && lu);
        flush_inc = !freeze && ex_redirect;
    end

    // Strobe decode by priority: reset, freeze, redirect, load-use, normal.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        memwb_flush = 1'b0;
        if (!rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            memwb_flush = 1'b1;
        end else if (freeze) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (ex_redirect) begin
            // The ID instruction is squashed, so a coincident load-use is moot.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (lu) begin
            // One bubble suffices: it clears ex_memread on the next cycle.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // Next-state logic for the memory-wait sequencer.
    always_comb begin
        state_nx = state;
        wait_nx  = wait_cnt;
        err_nx   = mem_err;
        case (state)
            RUN: begin
                if (mem_req && !mem_ack) begin
                    state_nx = MEM_WAIT;
                    wait_nx  = '0;
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    state_nx = RUN;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nx = HALT;
                    err_nx   = 1'b1;
                end else begin
                    wait_nx = wait_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = HALT;
            end
        endcase
    end

    // State, wait counter and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
            mem_err  <= err_nx;
        end
    end

    assign halted = (state == HALT);

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic
// checked against a behavioural model of the sequencing rules.
module tb_pipeline_hazard_ctrl;

    localparam int ASIZE = 5;
    localparam int TMO   = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    localparam logic [6:0] S_RESET  = 7'b0000111;
    localparam logic [6:0] S_FREEZE = 7'b0000001;
    localparam logic [6:0] S_REDIR  = 7'b1111110;
    localparam logic [6:0] S_LU     = 7'b0011010;
    localparam logic [6:0] S_NORMAL = 7'b1111000;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [ASIZE-1:0] id_rs = '0, id_rt = '0, ex_waddr = '0;
    logic             id_uses_rt = 1'b0, ex_memread = 1'b0, ex_redirect = 1'b0;
    logic             mem_req = 1'b0, mem_ack = 1'b0;
    logic             pc_en, ifid_en, idex_en, exmem_en;
    logic             ifid_flush, idex_flush, memwb_flush, halted, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [6:0]       strb;

    int errors = 0;
    int checks = 0;

    // Model: busy = an access is outstanding, frozen = freeze cycles spent on it.
    bit m_busy, m_halt, m_err;
    int m_frozen, m_stall, m_flush;

    pipeline_hazard_ctrl #(.ASIZE(ASIZE), .MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_waddr(ex_waddr), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ack(mem_ack), .pc_en(pc_en), .ifid_en(ifid_en),
        .idex_en(idex_en), .exmem_en(exmem_en), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .memwb_flush(memwb_flush), .halted(halted),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    assign strb = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush};

    always #5 clk = ~clk;

    function automatic bit model_freeze();
        return m_halt || (!mem_ack && (m_busy || mem_req));
    endfunction

    function automatic bit model_lu();
        int w, s, t;
        w = int'(ex_waddr); s = int'(id_rs); t = int'(id_rt);
        return ex_memread && w != 0 && (w == s || (id_uses_rt && w == t));
    endfunction

    function automatic logic [6:0] model_strb();
        if (!rst) return S_RESET;
        if (model_freeze()) return S_FREEZE;
        if (ex_redirect) return S_REDIR;
        if (model_lu()) return S_LU;
        return S_NORMAL;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_halt = 0; m_err = 0; m_frozen = 0; m_stall = 0; m_flush = 0;
    endtask

    // Advance model and DUT across one posedge; returns at posedge+1.
    task automatic tick();
        bit fr, l, nb, nh, ne;
        int nf, ns, nl;
        fr = model_freeze(); l = model_lu();
        nb = m_busy; nh = m_halt; ne = m_err; nf = m_frozen;
        ns = m_stall; nl = m_flush;
        if (!m_halt) begin
            if (fr) begin
                nf = m_busy ? m_frozen + 1 : 1;
                nb = 1;
                ns = ns + 1;
                if (nf == TMO) begin nh = 1; ne = 1; nb = 0; end
            end else begin
                nb = 0; nf = 0;
                if (ex_redirect) nl = nl + 1;
                else if (l) ns = ns + 1;
            end
        end
        if (ns > CMAX) ns = CMAX;
        if (nl > CMAX) nl = CMAX;
        @(posedge clk);
        m_busy = nb; m_halt = nh; m_err = ne; m_frozen = nf; m_stall = ns; m_flush = nl;
        #1;
    endtask

    task automatic set_in(input int rs, input int rt, input bit urt, input bit mr,
                          input int wa, input bit rd, input bit rq, input bit ak);
        id_rs = ASIZE'(rs); id_rt = ASIZE'(rt); id_uses_rt = urt; ex_memread = mr;
        ex_waddr = ASIZE'(wa); ex_redirect = rd; mem_req = rq; mem_ack = ak;
    endtask

    task automatic apply_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checks++; if (strb !== S_RESET) begin errors++; $display("FAIL reset_strb got=%b exp=%b", strb, S_RESET); end
        checks++; if ({halted, mem_err} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {halted, mem_err}); end
        checks++; if ({stall_cnt, flush_cnt} !== '0) begin errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++; if (strb !== S_NORMAL) begin errors++; $display("FAIL reset_release got=%b exp=%b", strb, S_NORMAL); end
    endtask

    task automatic test_load_use();
        apply_reset();
        set_in(5, 0, 0, 1, 5, 0, 0, 0); #1;
        checks++; if (strb !== S_LU) begin errors++; $display("FAIL lu_strb got=%b exp=%b", strb, S_LU); end
        tick();
        checks++; if (stall_cnt !== CNT_W'(1)) begin errors++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
        set_in(5, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++; if (strb !== S_NORMAL) begin errors++; $display("FAIL lu_after got=%b exp=%b", strb, S_NORMAL); end
        tick();
        set_in(0, 0, 0, 1, 0, 0, 0, 0); #1;
        checks++; if (strb !== S_NORMAL) begin errors++; $display("FAIL lu_r0 got=%b exp=%b", strb, S_NORMAL); end
        set_in(3, 7, 1, 1, 7, 0, 0, 0); #1;
        checks++; if (strb !== S_LU) begin errors++; $display("FAIL lu_rt got=%b exp=%b", strb, S_LU); end
        set_in(3, 7, 0, 1, 7, 0, 0, 0); #1;
        checks++; if (strb !== S_NORMAL) begin errors++; $display("FAIL lu_rt_unused got=%b exp=%b", strb, S_NORMAL); end
        tick();
        checks++; if (stall_cnt !== CNT_W'(1)) begin errors++; $display("FAIL lu_no_stall got=%0d exp=1", stall_cnt); end
    endtask

    task automatic test_redirect_lu();
        apply_reset();
        set_in(5, 0, 0, 1, 5, 1, 0, 0); #1;
        checks++; if (strb !== S_REDIR) begin errors++; $display("FAIL redir_strb got=%b exp=%b", strb, S_REDIR); end
        tick();
        checks++; if (flush_cnt !== CNT_W'(1) || stall_cnt !== '0) begin errors++; $display("FAIL redir_cnt got=%0d/%0d exp=1/0", flush_cnt, stall_cnt); end
    endtask

    task automatic test_mem_wait();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 1, 0); #1;
            checks++; if (strb !== S_FREEZE) begin errors++; $display("FAIL memw_freeze%0d got=%b exp=%b", i, strb, S_FREEZE); end
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 1, 1); #1;
        checks++; if (strb !== S_NORMAL) begin errors++; $display("FAIL memw_ack got=%b exp=%b", strb, S_NORMAL); end
        tick();
        checks++; if (stall_cnt !== CNT_W'(3) || halted !== 1'b0) begin errors++; $display("FAIL memw_cnt got=%0d h=%b exp=3 h=0", stall_cnt, halted); end
        set_in(0, 0, 0, 0, 0, 0, 0, 0); #1;
        checks++; if (strb !== S_NORMAL) begin errors++; $display("FAIL memw_run got=%b exp=%b", strb, S_NORMAL); end
    endtask

    task automatic test_frozen_redirect();
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            set_in(0, 0, 0, 0, 0, 1, 1, 0); #1;
            checks++; if (strb !== S_FREEZE) begin errors++; $display("FAIL fzr_freeze%0d got=%b exp=%b", i, strb, S_FREEZE); end
            tick();
        end
        set_in(0, 0, 0, 0, 0, 1, 1, 1); #1;
        checks++; if (strb !== S_REDIR) begin errors++; $display("FAIL fzr_release got=%b exp=%b", strb, S_REDIR); end
        tick();
        checks++; if (flush_cnt !== CNT_W'(1) || stall_cnt !== CNT_W'(2)) begin errors++; $display("FAIL fzr_cnt got=%0d/%0d exp=1/2", flush_cnt, stall_cnt); end
    endtask

    task automatic test_timeout();
        apply_reset();
        for (int i = 0; i < TMO; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 1, 0); #1;
            checks++; if (strb !== S_FREEZE || halted !== 1'b0) begin errors++; $display("FAIL tmo_freeze%0d got=%b h=%b exp=%b h=0", i, strb, halted, S_FREEZE); end
            tick();
        end
        checks++; if (halted !== 1'b1 || mem_err !== 1'b1) begin errors++; $display("FAIL tmo_halt got=%b%b exp=11", halted, mem_err); end
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 0, 1, 1, 1); #1;
            checks++; if (strb !== S_FREEZE) begin errors++; $display("FAIL tmo_ack_ignored got=%b exp=%b", strb, S_FREEZE); end
            tick();
        end
        checks++; if (halted !== 1'b1 || stall_cnt !== CNT_W'(TMO) || flush_cnt !== '0) begin errors++; $display("FAIL tmo_hold got h=%b %0d/%0d exp h=1 %0d/0", halted, stall_cnt, flush_cnt, TMO); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({halted, mem_err} !== 2'b00 || stall_cnt !== '0) begin errors++; $display("FAIL tmo_async_rst got=%b%b %0d exp=00 0", halted, mem_err, stall_cnt); end
        model_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b1; #1;
        checks++; if (strb !== S_NORMAL) begin errors++; $display("FAIL tmo_run_again got=%b exp=%b", strb, S_NORMAL); end
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            set_in(2, 0, 0, 1, 2, 0, 0, 0);
            tick();
            checks++; if (int'(stall_cnt) !== m_stall) begin errors++; $display("FAIL sat_step%0d got=%0d exp=%0d", i, stall_cnt, m_stall); end
        end
        checks++; if (stall_cnt !== CNT_W'(15)) begin errors++; $display("FAIL sat_final got=%0d exp=15", stall_cnt); end
    endtask

    task automatic test_random();
        logic [6:0] e;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            if (m_halt && ($urandom_range(0, 3) == 0)) apply_reset();
            set_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, 1), $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 2) == 0), $urandom_range(0, 1));
            #1;
            e = model_strb();
            checks++; if (strb !== e) begin errors++; $display("FAIL rnd_strb%0d got=%b exp=%b", i, strb, e); end
            tick();
            checks++;
            if (halted !== m_halt || mem_err !== m_err || int'(stall_cnt) !== m_stall || int'(flush_cnt) !== m_flush) begin
                errors++;
                $display("FAIL rnd_regs%0d got h=%b e=%b s=%0d f=%0d exp h=%b e=%b s=%0d f=%0d",
                         i, halted, mem_err, stall_cnt, flush_cnt, m_halt, m_err, m_stall, m_flush);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_redirect_lu();
        test_mem_wait();
        test_frozen_redirect();
        test_timeout();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
